// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: rounding-mode encodings, flag bit positions and rounding decisions
package fp_norm_pkg;
   typedef logic [2:0] rmode_t;
   localparam rmode_t RNE = 3'd0;
   localparam rmode_t RTZ = 3'd1;
   localparam rmode_t RDN = 3'd2;
   localparam rmode_t RUP = 3'd3;
   localparam rmode_t RMM = 3'd4;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;
   function automatic logic round_inc(input rmode_t rmode, input logic sign, input logic lsb,
                                      input logic g, input logic s);
      return rmode == RNE ? g & (lsb | s) :
             rmode == RTZ ? 1'b0 :
             rmode == RDN ? sign & (g | s) :
             rmode == RUP ? !sign & (g | s) :
             rmode == RMM ? g : 1'b0;
   endfunction
   // true when an overflowing result saturates to infinity rather than max-finite
   function automatic logic overflow_inf(input rmode_t rmode, input logic sign);
      return rmode == RNE || rmode == RMM || (rmode == RDN && sign) || (rmode == RUP && !sign);
   endfunction
endpackage

// File: rtl/fp_normalize_round_pipe_lod.sv
// lead_one_detect: priority encoder returning the index of the most significant set bit
module lead_one_detect #(
   parameter int IN_WIDTH = 128
) (
   input  logic [IN_WIDTH-1:0]         value,
   output logic [$clog2(IN_WIDTH)-1:0] index,
   output logic                        zero
);
   always_comb begin
      index = '0;
      zero = 1'b1;
      for (int i = 0; i < IN_WIDTH; i++)
         if (value[i]) begin
            index = $clog2(IN_WIDTH)'(i);
            zero = 1'b0;
         end
   end
endmodule

// File: rtl/fp_normalize_round_pipe.sv
// fp_normalize_round_pipe: 2-stage normalize/round/pack with valid/ready; define FP_NORM_SUBNORMAL_EN for gradual underflow
module fp_normalize_round_pipe
   import fp_norm_pkg::*;
#(
   parameter int MANTISSA_SIZE = 52,
   parameter int EXPONENT_SIZE = 11,
   parameter int IN_WIDTH      = 128,
   parameter int FRAC_POS      = 104
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sign,
   input  logic [EXPONENT_SIZE+1:0]   in_exponent,
   input  logic [IN_WIDTH-1:0]        in_mantissa,
   input  logic [2:0]                 in_rmode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sign,
   output logic [EXPONENT_SIZE-1:0]   out_exponent,
   output logic [MANTISSA_SIZE-1:0]   out_mantissa,
   output logic [2:0]                 out_flags
);
   localparam int M = MANTISSA_SIZE;
   localparam int W = IN_WIDTH;
   localparam int ES = EXPONENT_SIZE;
   localparam int LW = $clog2(IN_WIDTH);
   localparam int EW = EXPONENT_SIZE + 4;
   localparam logic [EW-1:0] EMAX = EW'((1 << ES) - 1);
   logic s2_adv, lod_zero, s1_valid, s1_zero, s1_sign;
   logic [LW-1:0] lod_idx, s1_l;
   logic [EW-1:0] e_in, s1_e, sub_sh, rs, amt, en;
   logic [2:0] s1_rmode;
   logic [W-1:0] s1_m;
   logic tiny, rpos, g, st, nx, inc, carry, inf;
   logic [W+M:0] sh;
   logic [M:0] kept;
   logic [M+1:0] sum;
   logic [ES-1:0] exp_n;
   logic [M-1:0] frac_n;
   logic [2:0] flags_n;
   assign s2_adv = !out_valid | out_ready;
   assign in_ready = !s1_valid | s2_adv;
   lead_one_detect #(.IN_WIDTH(W)) u_lod (.value(in_mantissa), .index(lod_idx), .zero(lod_zero));
   assign e_in = {{(EW-ES-2){in_exponent[ES+1]}}, in_exponent} + EW'(lod_idx) - EW'(FRAC_POS);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         s1_zero <= 1'b0;
         s1_sign <= 1'b0;
         s1_l <= '0;
         s1_e <= '0;
         s1_rmode <= '0;
         s1_m <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         s1_zero <= lod_zero;
         s1_sign <= in_sign;
         s1_l <= lod_idx;
         s1_e <= e_in;
         s1_rmode <= in_rmode;
         s1_m <= in_mantissa;
      end
   // the mantissa is shifted inside a 2W window so the dropped bits land below bit W
   always_comb begin
      tiny = s1_e[EW-1] | ~|s1_e;
`ifdef FP_NORM_SUBNORMAL_EN
      sub_sh = tiny ? ((EW'(1) - s1_e) > EW'(W) ? EW'(W) : EW'(1) - s1_e) : '0;
`else
      sub_sh = '0;
`endif
      rs = EW'(s1_l) - EW'(M) + sub_sh;
      rpos = !rs[EW-1] & |rs;
      amt = rpos ? rs : -rs;
      sh = rpos ? (W+M+1)'({s1_m, {W{1'b0}}} >> amt) : (W+M+1)'({s1_m, {W{1'b0}}} << amt);
      kept = sh[W+M:W];
      g = sh[W-1];
      st = |sh[W-2:0];
      nx = g | st;
      inc = round_inc(s1_rmode, s1_sign, kept[0], g, st);
      sum = {1'b0, kept} + (M+2)'(inc);
      carry = sum[M+1];
      en = s1_e + EW'(carry);
      inf = overflow_inf(s1_rmode, s1_sign);
      exp_n = '0;
      frac_n = '0;
      flags_n = '0;
      if (!s1_zero && tiny) begin
`ifdef FP_NORM_SUBNORMAL_EN
         exp_n = ES'(sum[M]);
         frac_n = sum[M-1:0];
         flags_n[FLAG_UF] = nx;
         flags_n[FLAG_NX] = nx;
`else
         flags_n[FLAG_UF] = 1'b1;
         flags_n[FLAG_NX] = 1'b1;
`endif
      end else if (!s1_zero && en >= EMAX) begin
         exp_n = inf ? '1 : {{(ES-1){1'b1}}, 1'b0};
         frac_n = inf ? '0 : '1;
         flags_n[FLAG_OF] = 1'b1;
         flags_n[FLAG_NX] = 1'b1;
      end else if (!s1_zero) begin
         exp_n = en[ES-1:0];
         frac_n = carry ? sum[M:1] : sum[M-1:0];
         flags_n[FLAG_NX] = nx;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_sign <= 1'b0;
         out_exponent <= '0;
         out_mantissa <= '0;
         out_flags <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sign <= s1_sign;
            out_exponent <= exp_n;
            out_mantissa <= frac_n;
            out_flags <= flags_n;
         end
      end
endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// tb_fp_normalize_round_pipe: directed table, backpressure/reset sequences and random vectors vs a value-level model
module tb_fp_normalize_round_pipe;
   import fp_norm_pkg::*;
   typedef struct {
      logic         s;
      logic [12:0]  e;
      logic [127:0] m;
      logic [2:0]   rm;
      logic [10:0]  xe;
      logic [51:0]  xf;
      logic [2:0]   xfl;
   } vec_t;
   logic clk, rst, in_valid, in_ready, in_sign, out_valid, out_ready, out_sign;
   logic [12:0] in_exponent;
   logic [127:0] in_mantissa;
   logic [2:0] in_rmode, out_flags;
   logic [10:0] out_exponent;
   logic [51:0] out_mantissa;
   int n_cmp = 0, n_bad = 0;
   vec_t exp_q[$];
   vec_t tbl[17];
   vec_t idle_v, t4[4];
   fp_normalize_round_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
      .in_exponent(in_exponent), .in_mantissa(in_mantissa), .in_rmode(in_rmode),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
      .out_exponent(out_exponent), .out_mantissa(out_mantissa), .out_flags(out_flags)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end
   // exact value-level rounding: quotient and remainder of mantissa / 2^shift
   function automatic vec_t model(input vec_t t);
      vec_t r;
      int L, E, sh;
      logic [255:0] mm, q, rem, half;
      logic up, nx;
      r = t;
      r.xe = '0;
      r.xf = '0;
      r.xfl = '0;
      if (t.m == '0) return r;
      L = 0;
      for (int i = 0; i < 128; i++) if (t.m[i]) L = i;
      E = int'($signed(t.e)) + L - 104;
      sh = L - 52;
`ifdef FP_NORM_SUBNORMAL_EN
      if (E <= 0) sh += (1 - E > 128) ? 128 : 1 - E;
`else
      if (E <= 0) begin
         r.xfl = 3'b011;
         return r;
      end
`endif
      mm = {128'd0, t.m};
      if (sh > 0) begin
         q = mm >> sh;
         rem = mm - (q << sh);
         half = 256'd1 << (sh - 1);
      end else begin
         q = mm << (-sh);
         rem = '0;
         half = 256'd1;
      end
      nx = rem != '0;
      case (t.rm)
         3'd0: up = rem > half || (rem == half && q[0]);
         3'd2: up = t.s && nx;
         3'd3: up = !t.s && nx;
         3'd4: up = rem >= half;
         default: up = 1'b0;
      endcase
      q = q + 256'(up);
`ifdef FP_NORM_SUBNORMAL_EN
      if (E <= 0) begin
         r.xe = {10'd0, q[52]};
         r.xf = q[51:0];
         r.xfl = {1'b0, nx, nx};
         return r;
      end
`endif
      if (q[53]) begin
         q = q >> 1;
         E++;
      end
      if (E >= 2047) begin
         if (t.rm == 3'd0 || t.rm == 3'd4 || (t.rm == 3'd2 && t.s) || (t.rm == 3'd3 && !t.s))
            r.xe = 11'h7FF;
         else begin
            r.xe = 11'h7FE;
            r.xf = '1;
         end
         r.xfl = 3'b101;
         return r;
      end
      r.xe = E[10:0];
      r.xf = q[51:0];
      r.xfl = {2'b00, nx};
      return r;
   endfunction
   function automatic vec_t rand_vec();
      vec_t t;
      t.s = 1'($urandom_range(0, 1));
      t.rm = 3'($urandom_range(0, 4));
      t.m = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) t.m[50:0] = '0;
      if ($urandom_range(0, 31) == 0) t.m = '0;
      t.e = 13'($urandom_range(0, 2200)) - 13'd60;
      t.xe = '0;
      t.xf = '0;
      t.xfl = '0;
      return model(t);
   endfunction
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask
   task automatic step(input logic v, input vec_t t, input logic rdy, output logic acc);
      @(negedge clk);
      in_valid = v;
      in_sign = t.s;
      in_exponent = t.e;
      in_mantissa = t.m;
      in_rmode = t.rm;
      out_ready = rdy;
      #1;
      acc = v && in_ready;
      if (out_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_output: got out_valid=1 want no result pending");
         end else begin
            if (out_sign !== exp_q[0].s || out_exponent !== exp_q[0].xe ||
                out_mantissa !== exp_q[0].xf || out_flags !== exp_q[0].xfl) begin
               n_bad++;
               $display("FAIL result: got s=%b e=%h f=%h fl=%b want s=%b e=%h f=%h fl=%b (in e=%h m=%h rm=%0d)",
                        out_sign, out_exponent, out_mantissa, out_flags, exp_q[0].s, exp_q[0].xe,
                        exp_q[0].xf, exp_q[0].xfl, exp_q[0].e, exp_q[0].m, exp_q[0].rm);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      if (acc) exp_q.push_back(t);
   endtask
   task automatic send(input vec_t t);
      logic a;
      int c;
      a = 1'b0;
      c = 0;
      while (!a && c < 50) begin
         step(1'b1, t, $urandom_range(0, 3) != 0, a);
         c++;
      end
      if (!a) chk("send_timeout", 128'(a), 128'd1);
   endtask
   task automatic drain();
      logic a;
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 50) begin
         step(1'b0, idle_v, 1'b1, a);
         c++;
      end
      chk("drain_left", 128'(exp_q.size()), 128'd0);
   endtask
   initial begin
      logic a;
      int k, c;
      idle_v = '{1'b0, 13'd0, 128'd0, 3'd0, 11'd0, 52'd0, 3'd0};
      tbl[0]  = '{1'b0, 13'd1023, 128'd1 << 104, RNE, 11'd1023, 52'd0, 3'b000};
      tbl[1]  = '{1'b0, 13'd1023, 128'd1 << 105, RNE, 11'd1024, 52'd0, 3'b000};
      tbl[2]  = '{1'b0, 13'd1023, (128'd1 << 104) | (128'd1 << 51), RNE, 11'd1023, 52'd0, 3'b001};
      tbl[3]  = '{1'b0, 13'd1023, (128'd1 << 104) | (128'd1 << 51), RUP, 11'd1023, 52'd1, 3'b001};
      tbl[4]  = '{1'b0, 13'd1023, ((128'd1 << 54) - 128'd1) << 51, RNE, 11'd1024, 52'd0, 3'b001};
      tbl[5]  = '{1'b0, 13'd2046, ((128'd1 << 54) - 128'd1) << 51, RNE, 11'h7FF, 52'd0, 3'b101};
      tbl[6]  = '{1'b0, 13'd2046, ((128'd1 << 54) - 128'd1) << 51, RTZ, 11'h7FE, {52{1'b1}}, 3'b001};
      tbl[7]  = '{1'b1, 13'd1023, 128'd0, RNE, 11'd0, 52'd0, 3'b000};
`ifdef FP_NORM_SUBNORMAL_EN
      tbl[8]  = '{1'b0, 13'd0, 128'd1 << 104, RNE, 11'd0, 52'h8000000000000, 3'b000};
`else
      tbl[8]  = '{1'b0, 13'd0, 128'd1 << 104, RNE, 11'd0, 52'd0, 3'b011};
`endif
      tbl[9]  = '{1'b0, 13'd1127, 128'd3, RNE, 11'd1024, 52'h8000000000000, 3'b000};
      tbl[10] = '{1'b1, 13'd1023, (128'd1 << 104) | 128'd1, RDN, 11'd1023, 52'd1, 3'b001};
      tbl[11] = '{1'b0, 13'd1023, (128'd1 << 104) | 128'd1, RDN, 11'd1023, 52'd0, 3'b001};
      tbl[12] = '{1'b0, 13'd1023, (128'd1 << 104) | (128'd1 << 51), RMM, 11'd1023, 52'd1, 3'b001};
      tbl[13] = '{1'b0, 13'd2047, 128'd1 << 104, RDN, 11'h7FE, {52{1'b1}}, 3'b101};
      tbl[14] = '{1'b1, 13'd2047, 128'd1 << 104, RUP, 11'h7FE, {52{1'b1}}, 3'b101};
      tbl[15] = '{1'b0, 13'd2047, 128'd1 << 104, RUP, 11'h7FF, 52'd0, 3'b101};
      tbl[16] = '{1'b1, 13'd2047, 128'd1 << 104, RTZ, 11'h7FE, {52{1'b1}}, 3'b101};
      rst = 1'b1;
      in_valid = 1'b0;
      in_sign = 1'b0;
      in_exponent = '0;
      in_mantissa = '0;
      in_rmode = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_outputs", 128'({out_sign, out_exponent, out_mantissa, out_flags}), 128'd0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) send(tbl[i]);
      drain();
      for (int i = 0; i < 4; i++) t4[i] = rand_vec();
      k = 0;
      for (int i = 0; i < 6; i++) begin
         step(k < 4, t4[k < 4 ? k : 3], 1'b0, a);
         if (a) k++;
      end
      chk("bp_accepted", 128'(k), 128'd2);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      c = 0;
      while ((k < 4 || exp_q.size() != 0) && c < 40) begin
         step(k < 4, t4[k < 4 ? k : 3], 1'b1, a);
         if (a) k++;
         c++;
      end
      chk("bp_release_done", 128'(exp_q.size() + 4 - k), 128'd0);
      step(1'b1, tbl[0], 1'b0, a);
      step(1'b1, tbl[1], 1'b0, a);
      @(posedge clk);
      #2;
      chk("pre_rst_out_valid", 128'(out_valid), 128'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
      chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
      chk("rst_mid_outputs", 128'({out_sign, out_exponent, out_mantissa, out_flags}), 128'd0);
      exp_q.delete();
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, idle_v, 1'b1, a);
      send(tbl[4]);
      drain();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) step(1'b0, idle_v, $urandom_range(0, 1) != 0, a);
         send(rand_vec());
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
